// File: rtl/sr_ctrl_pkg.sv
// Shared encodings for the SR flag arbiter:
// controller states and requester operation codes.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GUARD = 2'd2
   } state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request
// at or after ptr, one-hot result plus valid.
module rr_arbiter #(
   parameter int N = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic          valid
);

   logic [PW-1:0] k;
   logic          found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 0; i < N; i++) begin
         k = PW'((int'(ptr) + i) % N);
         if (en && !found && req[k]) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign valid = found;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin controller driving a bank of gated SR flops,
// one pulsed strobe at a time, with a shadow of the bank.
module sr_flag_arbiter
   import sr_ctrl_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int PULSE = 2,
   localparam int IDXW = $clog2(NFLAG)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ*IDXW-1:0] req_idx,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic [NFLAG-1:0]     s_out,
   output logic [NFLAG-1:0]     r_out,
   output logic [NFLAG-1:0]     flag_q,
   output logic                 err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;

   state_t          state;
   logic [PW-1:0]   rr;
   logic [PW-1:0]   rr_nxt;
   logic [CW-1:0]   cnt;
   logic            op_q;
   logic [IDXW-1:0] idx_q;

   logic [NREQ-1:0]  win_oh;
   logic             win_vld;
   logic [PW-1:0]    win_id;
   logic             win_op;
   logic [IDXW-1:0]  win_fi;
   logic [NFLAG-1:0] win_dec;
   logic [NFLAG-1:0] cur_dec;
   logic             win_oor;
   logic             win_hit;
   logic             win_eff;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req   (req),
      .ptr   (rr),
      .en    (state == ST_IDLE),
      .gnt   (win_oh),
      .valid (win_vld)
   );

   always_comb begin
      win_id = '0;
      win_op = 1'b0;
      win_fi = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            win_id = PW'(i);
            win_op = req_op[i];
            win_fi = req_idx[i*IDXW +: IDXW];
         end
      end
   end

   // Out-of-range indices shift the one-hot out entirely.
   assign win_dec = NFLAG'(1) << win_fi;
   assign cur_dec = NFLAG'(1) << idx_q;
   assign win_oor = int'(win_fi) >= NFLAG;
   assign win_hit = |(flag_q & win_dec);
   assign win_eff = win_hit != (win_op == OP_SET);
   assign rr_nxt  = (win_id == PW'(NREQ - 1)) ? '0 : win_id + 1'b1;
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         rr     <= '0;
         cnt    <= '0;
         op_q   <= OP_CLR;
         idx_q  <= '0;
         gnt    <= '0;
         err    <= 1'b0;
         s_out  <= '0;
         r_out  <= '0;
         flag_q <= '0;
      end else begin
         gnt <= '0;
         err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  gnt   <= win_oh;
                  err   <= win_oor;
                  rr    <= rr_nxt;
                  op_q  <= win_op;
                  idx_q <= win_fi;
                  if (!win_oor && win_eff) begin
                     state <= ST_DRIVE;
                     cnt   <= CW'(PULSE - 1);
                     if (win_op == OP_SET) s_out <= win_dec;
                     else                  r_out <= win_dec;
                  end
               end
            end
            ST_DRIVE: begin
               if (cnt == '0) begin
                  flag_q <= (op_q == OP_SET) ? (flag_q | cur_dec)
                                             : (flag_q & ~cur_dec);
                  s_out  <= '0;
                  r_out  <= '0;
                  state  <= ST_GUARD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_GUARD: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule
